// File: rtl/if1_host_tx_if.sv
// Producer stream, serial link (one/two) and status signals for if1_host_tx.
interface if1_host_tx_if #(
   parameter int DW = 8
);
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          one;
   logic          two;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  tx_data, tx_valid, two,
      output tx_ready, one, busy, done, err
   );

   modport slave (
      output tx_data, tx_valid, two,
      input  tx_ready, one, busy, done, err
   );
endinterface

// File: rtl/if1_host_tx.sv
// Framed serial transmitter with acknowledge timeout and bounded retransmission.
// Define IF1_HOST_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module if1_host_tx #(
   parameter int DW          = 8,
   parameter int BIT_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   if1_host_tx_if.master bus
);
   localparam int CW = (BIT_CYCLES > 1)  ? $clog2(BIT_CYCLES)    : 1;
   localparam int BW = (DW > 1)          ? $clog2(DW)            : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT)   : 1;
   localparam int RW = (MAX_RETRY > 0)   ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef IF1_HOST_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_ACK
   } state_e;

`ifdef IF1_HOST_TX_PARITY_EN
   localparam state_e AFTER_DATA = S_PARITY;
`else
   localparam state_e AFTER_DATA = S_STOP;
`endif

   state_e        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [TW-1:0] to_q, to_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          one_c;
   logic          slot_end;

   assign slot_end = (cyc_q == CYC_LAST);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      to_d    = to_q;
      retry_d = retry_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      one_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.tx_valid && ready_q) begin
               data_d  = bus.tx_data;
               retry_d = '0;
               cyc_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            one_c = 1'b1;
            if (slot_end) begin
               cyc_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_DATA: begin
            one_c = data_q[bit_q];
            if (slot_end) begin
               cyc_d = '0;
               if (bit_q == BIT_LAST) state_d = AFTER_DATA;
               else                   bit_d   = bit_q + 1'b1;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
`ifdef IF1_HOST_TX_PARITY_EN
         S_PARITY: begin
            one_c = ^data_q;
            if (slot_end) begin
               cyc_d   = '0;
               state_d = S_STOP;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (slot_end) begin
               cyc_d   = '0;
               to_d    = '0;
               state_d = S_WAIT_ACK;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_WAIT_ACK: begin
            // acknowledge is tested first so it wins over a coincident timeout
            if (bus.two) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (to_q == TO_LAST) begin
               to_d = '0;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_START;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cyc_q   <= '0;
         bit_q   <= '0;
         to_q    <= '0;
         retry_q <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         to_q    <= to_d;
         retry_q <= retry_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.tx_ready = ready_q;
   assign bus.one      = one_c;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule
